seq_magnitude_comparator: RTL

- Parametrised, multi-cycle magnitude comparator that supersedes the fixed 3-bit combinational comparator.
- Compares two WIDTH-bit operands DIGIT bits per cycle, MSB-first, and stops early at the first differing digit.
- Supports unsigned and two's-complement signed modes.
- Uses a start/busy/done handshake and sits beside the ALU datapath, feeding branch/flag logic.

---
 rtl/seq_magnitude_comparator_pkg.sv | 21 ++
 rtl/seq_magnitude_comparator_digit.sv | 17 +
 rtl/seq_magnitude_comparator.sv | 121 ++++++++++++
 3 files changed

// File: rtl/seq_magnitude_comparator_pkg.sv
// cmp_pkg: shared types and constants for the sequential magnitude comparator.
//   state_t       - FSM encoding (IDLE, SCAN)
//   CMP_UNSIGNED  - signed_mode value for unsigned compare
//   CMP_SIGNED    - signed_mode value for two's-complement compare
//   idx_width()   - digit index register width for a given digit count
package cmp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic CMP_UNSIGNED = 1'b0;
  localparam logic CMP_SIGNED   = 1'b1;

  // A single-digit compare still needs a 1-bit index register.
  function automatic int idx_width(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage

// File: rtl/seq_magnitude_comparator_digit.sv
// cmp_digit: combinational unsigned compare of one DIGIT-bit digit.
//   da, db - digit of operand A / B
//   lt     - da < db
//   gt     - da > db
module cmp_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] da,
  input  logic [DIGIT-1:0] db,
  output logic             lt,
  output logic             gt
);

  assign lt = (da < db);
  assign gt = (da > db);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// seq_magnitude_comparator: multi-cycle MSB-first magnitude comparator.
// Scans DIGIT bits per cycle and finishes at the first differing digit.
//   clk, rst_n          - clock, async active-low reset
//   start               - request compare (accepted only in IDLE)
//   signed_mode         - 1: two's-complement, 0: unsigned (sampled with start)
//   a, b                - operands (sampled with start)
//   busy                - high while scanning
//   done                - one-cycle result-valid pulse
//   less, equal, greater - registered result, held until next accepted start
// WIDTH must be >= 2 and a multiple of DIGIT.
module seq_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             less,
  output logic             equal,
  output logic             greater
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int IW   = idx_width(NDIG);
  localparam logic [WIDTH-1:0] MSB    = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [IW-1:0]    IDX_HI = IW'(NDIG - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] opa, opb;
  logic [WIDTH-1:0] sha, shb;
  logic [31:0]      sh_amt;
  logic [IW-1:0]    idx;
  logic [DIGIT-1:0] da, db;
  logic             lt, gt, last;

  // Select the current digit by shifting it down to bit 0.
  assign sh_amt = 32'(idx) * 32'(DIGIT);
  assign sha    = opa >> sh_amt;
  assign shb    = opb >> sh_amt;
  assign da     = sha[DIGIT-1:0];
  assign db     = shb[DIGIT-1:0];
  assign last   = (idx == '0);

  cmp_digit #(.DIGIT(DIGIT)) u_dig (
    .da (da),
    .db (db),
    .lt (lt),
    .gt (gt)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = SCAN;
      SCAN: if (lt || gt || last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = 1'b0;
    if (state == SCAN) busy = 1'b1;
  end

  // Operands, digit index, result flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa     <= '0;
      opb     <= '0;
      idx     <= '0;
      done    <= 1'b0;
      less    <= 1'b0;
      equal   <= 1'b0;
      greater <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          // Flipping both MSBs maps two's-complement order onto unsigned order.
          opa     <= (signed_mode == CMP_SIGNED) ? (a ^ MSB) : a;
          opb     <= (signed_mode == CMP_SIGNED) ? (b ^ MSB) : b;
          idx     <= IDX_HI;
          less    <= 1'b0;
          equal   <= 1'b0;
          greater <= 1'b0;
        end
        SCAN: begin
          if (gt) begin
            greater <= 1'b1;
            done    <= 1'b1;
          end else if (lt) begin
            less <= 1'b1;
            done <= 1'b1;
          end else if (last) begin
            equal <= 1'b1;
            done  <= 1'b1;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
